// File: rtl/hlang_token_pkg.sv
// Shared token, character and lexer-state definitions for the Hlang front end.
// The parser side imports token_t from here so both ends agree on the token layout.
package hlang_token_pkg;

    localparam logic [7:0] KIND_NUM         = 8'd1;
    localparam logic [7:0] KIND_PLUS        = 8'd2;
    localparam logic [7:0] KIND_MINUS       = 8'd3;
    localparam logic [7:0] KIND_STAR        = 8'd4;
    localparam logic [7:0] KIND_SLASH       = 8'd5;
    localparam logic [7:0] KIND_LPAREN      = 8'd6;
    localparam logic [7:0] KIND_RPAREN      = 8'd7;
    localparam logic [7:0] KIND_EOF_DEFAULT = 8'h00;

    localparam logic [7:0] CH_0      = 8'h30;
    localparam logic [7:0] CH_9      = 8'h39;
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_TAB    = 8'h09;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_PLUS   = 8'h2B;
    localparam logic [7:0] CH_MINUS  = 8'h2D;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_SLASH  = 8'h2F;
    localparam logic [7:0] CH_LPAREN = 8'h28;
    localparam logic [7:0] CH_RPAREN = 8'h29;

    typedef enum logic [2:0] {
        S_SCAN,
        S_EMIT,
        S_GAP,
        S_DONE,
        S_ERROR
    } lex_state_e;

    typedef struct packed {
        logic [7:0] kind;
        logic [7:0] value;
    } token_t;

    // A queued token plus a marker so EOF is recognised independent of EOF_KIND.
    typedef struct packed {
        logic   eof;
        token_t tok;
    } lex_item_t;

    typedef struct packed {
        logic       is_digit;
        logic       is_ws;
        logic       is_op;
        logic [7:0] op_kind;
        logic [3:0] digit;
    } char_class_t;

    function automatic lex_item_t make_item(input logic eof, input logic [7:0] kind,
                                            input logic [7:0] value);
        lex_item_t item;
        item.eof       = eof;
        item.tok.kind  = kind;
        item.tok.value = value;
        return item;
    endfunction

endpackage

// File: rtl/hlang_char_class.sv
// Combinational byte classifier: digit / whitespace / operator-or-paren, with the
// operator's token kind and the digit's numeric value.
module hlang_char_class
    import hlang_token_pkg::*;
(
    input  logic [7:0]  ch,
    output char_class_t cls
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a field unassigned (no latch).
        cls          = '0;
        cls.digit    = ch[3:0];
        cls.is_digit = (ch >= CH_0) && (ch <= CH_9);
        unique case (ch)
            CH_SPACE, CH_TAB, CH_LF, CH_CR: cls.is_ws = 1'b1;
            CH_PLUS:   begin cls.is_op = 1'b1; cls.op_kind = KIND_PLUS;   end
            CH_MINUS:  begin cls.is_op = 1'b1; cls.op_kind = KIND_MINUS;  end
            CH_STAR:   begin cls.is_op = 1'b1; cls.op_kind = KIND_STAR;   end
            CH_SLASH:  begin cls.is_op = 1'b1; cls.op_kind = KIND_SLASH;  end
            CH_LPAREN: begin cls.is_op = 1'b1; cls.op_kind = KIND_LPAREN; end
            CH_RPAREN: begin cls.is_op = 1'b1; cls.op_kind = KIND_RPAREN; end
            default: ;
        endcase
    end

endmodule

// File: rtl/hlang_lexer.sv
// Hlang byte-stream lexer feeding the LR parser's token port with a valid/RECEIVE handshake.
// Build option: define HLANG_LEXER_OVERFLOW_ERR_EN to flag number literals above 255 as errors.
module hlang_lexer
    import hlang_token_pkg::*;
#(
    parameter int         MAX_DIGITS = 3,
    parameter logic [7:0] EOF_KIND   = KIND_EOF_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        I_VALID,
    input  logic [7:0]  I_DATA,
    input  logic        I_LAST,
    output logic        I_READY,
    output logic        O_VALID,
    output logic [15:0] O_TOKEN,
    input  logic        RECEIVE,
    output logic [2:0]  STAT
);

    localparam int                  DCNT_W   = $clog2(MAX_DIGITS + 1);
    localparam logic [DCNT_W-1:0]   MAX_DCNT = DCNT_W'(MAX_DIGITS);

    lex_state_e        state, state_n;
    logic [7:0]        acc, acc_n;
    logic [DCNT_W-1:0] dcnt, dcnt_n;
    logic              in_num, in_num_n;
    lex_item_t         cur, cur_n;
    lex_item_t         pend0, pend0_n;
    lex_item_t         pend1, pend1_n;
    logic [1:0]        pend_cnt, pend_cnt_n;

    char_class_t       cls;
    logic [11:0]       acc_wide;
    logic              digit_err;
    logic              accept;
    lex_item_t         num_item, op_item, eof_item;

    hlang_char_class u_char_class (
        .ch  (I_DATA),
        .cls (cls)
    );

    assign acc_wide = 12'(acc) * 12'd10 + 12'(cls.digit);

`ifdef HLANG_LEXER_OVERFLOW_ERR_EN
    assign digit_err = (dcnt == MAX_DCNT) || (acc_wide > 12'd255);
`else
    assign digit_err = (dcnt == MAX_DCNT);
`endif

    assign accept   = I_VALID && I_READY;
    assign num_item = make_item(1'b0, KIND_NUM, acc);
    assign op_item  = make_item(1'b0, cls.op_kind, 8'h00);
    assign eof_item = make_item(1'b1, EOF_KIND, 8'h00);

    // NOTE: synchronous reset clears every register, including the pending slots, so nothing
    // half-built survives RST.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_SCAN;
            acc      <= '0;
            dcnt     <= '0;
            in_num   <= 1'b0;
            cur      <= '0;
            pend0    <= '0;
            pend1    <= '0;
            pend_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state    <= state_n;
            acc      <= acc_n;
            dcnt     <= dcnt_n;
            in_num   <= in_num_n;
            cur      <= cur_n;
            pend0    <= pend0_n;
            pend1    <= pend1_n;
            pend_cnt <= pend_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        acc_n      = acc;
        dcnt_n     = dcnt;
        in_num_n   = in_num;
        cur_n      = cur;
        pend0_n    = pend0;
        pend1_n    = pend1;
        pend_cnt_n = pend_cnt;

        unique case (state)
            S_SCAN: begin
                if (accept) begin
                    if (cls.is_digit) begin
                        if (digit_err) begin
                            state_n = S_ERROR;
                        end else if (I_LAST) begin
                            cur_n      = make_item(1'b0, KIND_NUM, acc_wide[7:0]);
                            pend0_n    = eof_item;
                            pend_cnt_n = 2'd1;
                            acc_n      = '0;
                            dcnt_n     = '0;
                            in_num_n   = 1'b0;
                            state_n    = S_EMIT;
                        end else begin
                            acc_n    = acc_wide[7:0];
                            dcnt_n   = dcnt + DCNT_W'(1);
                            in_num_n = 1'b1;
                        end
                    end else if (cls.is_ws) begin
                        if (in_num) begin
                            cur_n      = num_item;
                            pend0_n    = eof_item;
                            pend_cnt_n = I_LAST ? 2'd1 : 2'd0;
                            acc_n      = '0;
                            dcnt_n     = '0;
                            in_num_n   = 1'b0;
                            state_n    = S_EMIT;
                        end else if (I_LAST) begin
                            cur_n   = eof_item;
                            state_n = S_EMIT;
                        end
                    end else if (cls.is_op) begin
                        if (in_num) begin
                            // The number ends here; the operator waits its turn behind it.
                            cur_n      = num_item;
                            pend0_n    = op_item;
                            pend1_n    = eof_item;
                            pend_cnt_n = I_LAST ? 2'd2 : 2'd1;
                            acc_n      = '0;
                            dcnt_n     = '0;
                            in_num_n   = 1'b0;
                        end else begin
                            cur_n      = op_item;
                            pend0_n    = eof_item;
                            pend_cnt_n = I_LAST ? 2'd1 : 2'd0;
                        end
                        state_n = S_EMIT;
                    end else begin
                        state_n = S_ERROR;
                    end

                    if (state_n == S_ERROR) begin
                        cur_n      = '0;
                        pend0_n    = '0;
                        pend1_n    = '0;
                        pend_cnt_n = '0;
                        acc_n      = '0;
                        dcnt_n     = '0;
                        in_num_n   = 1'b0;
                    end
                end
            end

            S_EMIT: begin
                if (RECEIVE) begin
                    if (cur.eof)             state_n = S_DONE;
                    else if (pend_cnt != '0) state_n = S_GAP;
                    else                     state_n = S_SCAN;
                end
            end

            S_GAP: begin
                cur_n      = pend0;
                pend0_n    = pend1;
                pend1_n    = '0;
                pend_cnt_n = pend_cnt - 2'd1;
                state_n    = S_EMIT;
            end

            S_DONE:  ;
            S_ERROR: ;
            default: state_n = S_ERROR;
        endcase
    end

    // NOTE: outputs are forced to reset values while RST is high, since the state register
    // alone would already show S_SCAN (ready) during a held reset.
    always_comb begin
        I_READY = 1'b0;
        O_VALID = 1'b0;
        O_TOKEN = '0;
        STAT    = 3'b100;
        if (!RST) begin
            unique case (state)
                S_SCAN:  I_READY = 1'b1;
                S_EMIT:  begin O_VALID = 1'b1; O_TOKEN = cur.tok; end
                S_DONE:  STAT = 3'b010;
                S_ERROR: STAT = 3'b001;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hlang_lexer.sv
// Directed bench for hlang_lexer: expected tokens are queued as bytes are driven and
// compared as the lexer presents them.
module tb_hlang_lexer;
    import hlang_token_pkg::*;

    logic        CLK     = 1'b0;
    logic        RST     = 1'b1;
    logic        I_VALID = 1'b0;
    logic [7:0]  I_DATA  = 8'h00;
    logic        I_LAST  = 1'b0;
    logic        RECEIVE = 1'b0;
    logic        I_READY;
    logic        O_VALID;
    logic [15:0] O_TOKEN;
    logic [2:0]  STAT;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] sb[$];

    hlang_lexer dut (
        .CLK     (CLK),
        .RST     (RST),
        .I_VALID (I_VALID),
        .I_DATA  (I_DATA),
        .I_LAST  (I_LAST),
        .I_READY (I_READY),
        .O_VALID (O_VALID),
        .O_TOKEN (O_TOKEN),
        .RECEIVE (RECEIVE),
        .STAT    (STAT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_ready", 16'(I_READY), 16'd0);
        check("rst_valid", 16'(O_VALID), 16'd0);
        check("rst_token", O_TOKEN, 16'h0000);
        check("rst_stat",  16'(STAT), 16'(3'b100));
        check("sb_drained", 16'(sb.size()), 16'd0);
        sb.delete();
        RST = 1'b0;
    endtask

    // Drive one byte; expect_tok says whether a token must be valid the cycle after acceptance.
    task automatic send_byte(input logic [7:0] ch, input logic last, input logic expect_tok);
        int w = 0;
        @(negedge CLK);
        while (!I_READY && w < 50) begin
            @(negedge CLK);
            w++;
        end
        check("ready_wait", 16'(I_READY), 16'd1);
        I_DATA  = ch;
        I_LAST  = last;
        I_VALID = 1'b1;
        @(negedge CLK);
        I_VALID = 1'b0;
        I_LAST  = 1'b0;
        check("latency", 16'(O_VALID), 16'(expect_tok));
    endtask

    // Wait (bounded) for a token, compare it with the scoreboard head, hold it, then consume it.
    task automatic recv(input int hold, input int max_wait);
        int          w = 0;
        logic [15:0] exp;
        logic [15:0] first;
        logic        steady = 1'b1;
        while (!O_VALID && w < max_wait) begin
            @(negedge CLK);
            w++;
        end
        check("valid_wait", 16'(O_VALID), 16'd1);
        exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
        check("token", O_TOKEN, exp);
        first = O_TOKEN;
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            if (O_TOKEN !== first || O_VALID !== 1'b1 || I_READY !== 1'b0) steady = 1'b0;
        end
        if (hold > 0) check("hold_stable", 16'(steady), 16'd1);
        RECEIVE = 1'b1;
        @(negedge CLK);
        RECEIVE = 1'b0;
        check("gap_low", 16'(O_VALID), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, then first cycle out of reset is scanning.
        do_reset();
        @(negedge CLK);
        check("scan_ready", 16'(I_READY), 16'd1);
        check("scan_stat", 16'(STAT), 16'(3'b100));

        // "12+3" with I_LAST on '3'.
        sb.push_back(16'h010C);
        sb.push_back(16'h0200);
        send_byte("1", 1'b0, 1'b0);
        send_byte("2", 1'b0, 1'b0);
        send_byte("+", 1'b0, 1'b1);
        recv(2, 4);
        recv(2, 1);
        sb.push_back(16'h0103);
        sb.push_back(16'h0000);
        send_byte("3", 1'b1, 1'b1);
        recv(2, 1);
        recv(2, 1);
        check("done_stat", 16'(STAT), 16'(3'b010));
        check("done_ready", 16'(I_READY), 16'd0);
        RECEIVE = 1'b1;
        @(negedge CLK);
        RECEIVE = 1'b0;
        @(negedge CLK);
        check("done_sticky", 16'(STAT), 16'(3'b010));
        check("done_valid", 16'(O_VALID), 16'd0);

        // "( 7 )" with I_LAST on ')'; whitespace alone yields nothing.
        do_reset();
        sb.push_back(16'h0600);
        send_byte("(", 1'b0, 1'b1);
        recv(2, 4);
        send_byte(" ", 1'b0, 1'b0);
        send_byte("7", 1'b0, 1'b0);
        sb.push_back(16'h0107);
        send_byte(" ", 1'b0, 1'b1);
        recv(2, 4);
        sb.push_back(16'h0700);
        sb.push_back(16'h0000);
        send_byte(")", 1'b1, 1'b1);
        recv(2, 1);
        recv(2, 1);
        check("paren_done", 16'(STAT), 16'(3'b010));

        // "9*" with RECEIVE withheld 10 cycles; operator follows after one gap cycle.
        do_reset();
        sb.push_back(16'h0109);
        sb.push_back(16'h0400);
        send_byte("9", 1'b0, 1'b0);
        send_byte("*", 1'b0, 1'b1);
        recv(10, 4);
        recv(1, 1);
        @(negedge CLK);
        check("back_to_scan", 16'(I_READY), 16'd1);

        // "300": overflow error when enabled, wraps to 44 otherwise.
        do_reset();
        send_byte("3", 1'b0, 1'b0);
        send_byte("0", 1'b0, 1'b0);
`ifdef HLANG_LEXER_OVERFLOW_ERR_EN
        send_byte("0", 1'b1, 1'b0);
        check("ovf_stat", 16'(STAT), 16'(3'b001));
        check("ovf_ready", 16'(I_READY), 16'd0);
`else
        sb.push_back(16'h012C);
        sb.push_back(16'h0000);
        send_byte("0", 1'b1, 1'b1);
        recv(2, 1);
        recv(2, 1);
        check("wrap_done", 16'(STAT), 16'(3'b010));
`endif

        // Fourth digit exceeds the digit limit.
        do_reset();
        send_byte("1", 1'b0, 1'b0);
        send_byte("2", 1'b0, 1'b0);
        send_byte("3", 1'b0, 1'b0);
        send_byte("4", 1'b0, 1'b0);
        check("maxdig_stat", 16'(STAT), 16'(3'b001));

        // Number terminated by a space, then an illegal byte.
        do_reset();
        sb.push_back(16'h0101);
        send_byte("1", 1'b0, 1'b0);
        send_byte(" ", 1'b0, 1'b1);
        recv(2, 4);
        send_byte("a", 1'b0, 1'b0);
        check("err_stat", 16'(STAT), 16'(3'b001));
        check("err_ready", 16'(I_READY), 16'd0);
        check("err_token", O_TOKEN, 16'h0000);
        repeat (3) @(negedge CLK);
        check("err_sticky", 16'(STAT), 16'(3'b001));

        // Reset mid-number drops the partial literal.
        do_reset();
        send_byte("4", 1'b0, 1'b0);
        send_byte("5", 1'b0, 1'b0);
        do_reset();
        sb.push_back(16'h0106);
        sb.push_back(16'h0000);
        send_byte("6", 1'b1, 1'b1);
        recv(2, 1);
        recv(2, 1);
        check("rst_mid_done", 16'(STAT), 16'(3'b010));
        check("sb_final", 16'(sb.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
